// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan
// Purpose  : Eight-digit multiplexed seven-segment scan driver for a
//            common-anode display. Shows a 32-bit word as eight hex digits.
//            The word is latched once per scan frame so a frame never mixes
//            old and new data.
// Ports    : clk   - system clock, rising edge
//            rst   - asynchronous reset, active-low
//            din   - 32-bit display word
//            an    - digit enables, active-low, an[0] = rightmost (din[3:0])
//            seg   - segments {g,f,e,d,c,b,a}, active-low
//            dp    - decimal point, active-low, always off
//            frame - one-cycle pulse in the cycle after a frame load
// Config   : SEG7_LZB_EN - when defined, leading zero digits are blanked
//            (digit 0 is never blanked).
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  // Prescaler width: at least one bit so SCAN_DIV = 1 still elaborates.
  localparam int            CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shown_q, shown_d;
  logic             frame_q, frame_d;

  logic             w_tick;
  logic [3:0]       w_nib;
  logic             w_blank;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_tick  = (cnt_q == c_cnt_last);
    cnt_d   = w_tick ? '0 : cnt_q + 1'b1;
    idx_d   = w_tick ? idx_q + 3'd1 : idx_q;
    // Frame boundary: last tick of digit 7. din is sampled only here.
    frame_d = w_tick && (idx_q == 3'd7);
    shown_d = frame_d ? din : shown_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shown_q <= 32'd0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shown_q <= shown_d;
      frame_q <= frame_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state only, never from din.
  // --------------------------------------------------------------------------
  always_comb begin
    w_nib = shown_q[{idx_q, 2'b00} +: 4];

`ifdef SEG7_LZB_EN
    // Blank when every nibble at or above the current digit is zero.
    w_blank = (idx_q != 3'd0) && ((shown_q >> {idx_q, 2'b00}) == 32'd0);
`else
    w_blank = 1'b0;
`endif

    case (w_nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase

    an = ~(8'b1 << idx_q);

    if (w_blank) begin
      an  = 8'hFF;
      seg = 7'h7F;
    end
  end

  assign dp    = 1'b1;
  assign frame = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan
// Purpose  : Self-checking bench for seg7_scan. Two instances share clock,
//            reset and data: one with SCAN_DIV = 2, one with SCAN_DIV = 1.
//            Expected outputs come from an edge-count model of the scan.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan;

  localparam int SD0 = 2;
  localparam int SD1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] din = 32'd0;

  logic [7:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, frame0, frame1;

  int checks = 0;
  int errors = 0;

  seg7_scan #(.SCAN_DIV(SD0)) dut0 (
    .clk(clk), .rst(rst), .din(din),
    .an(an0), .seg(seg0), .dp(dp0), .frame(frame0)
  );

  seg7_scan #(.SCAN_DIV(SD1)) dut1 (
    .clk(clk), .rst(rst), .din(din),
    .an(an1), .seg(seg1), .dp(dp1), .frame(frame1)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: count rising edges since reset release. Every
  // 8*SCAN_DIV edges the word present at that edge becomes the shown value.
  // --------------------------------------------------------------------------
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          e   = 0;
  logic [31:0] sm0 = 32'd0;
  logic [31:0] sm1 = 32'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e   <= 0;
      sm0 <= 32'd0;
      sm1 <= 32'd0;
    end else begin
      e <= e + 1;
      if ((e + 1) % (8 * SD0) == 0) sm0 <= din;
      if ((e + 1) % (8 * SD1) == 0) sm1 <= din;
    end
  end

  function automatic logic m_blank(int edges, int sd, logic [31:0] sh);
    int d;
    d = (edges / sd) % 8;
`ifdef SEG7_LZB_EN
    return (d != 0) && ((sh >> (4 * d)) == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] m_an(int edges, int sd, logic [31:0] sh);
    int d;
    d = (edges / sd) % 8;
    if (m_blank(edges, sd, sh)) return 8'hFF;
    return 8'hFF ^ (8'd1 << d);
  endfunction

  function automatic logic [6:0] m_seg(int edges, int sd, logic [31:0] sh);
    int d;
    d = (edges / sd) % 8;
    if (m_blank(edges, sd, sh)) return 7'h7F;
    return hex_tab[(sh >> (4 * d)) & 32'hF];
  endfunction

  function automatic logic m_frame(int edges, int sd);
    return (edges > 0) && (edges % (8 * sd) == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t e=%0d)", name, act, exp, $time, e);
    end
  endtask

  // Continuous compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("an0",    32'(an0),    32'(m_an(e, SD0, sm0)));
    chk("seg0",   32'(seg0),   32'(m_seg(e, SD0, sm0)));
    chk("dp0",    32'(dp0),    32'd1);
    chk("frame0", 32'(frame0), 32'(m_frame(e, SD0)));
    chk("an1",    32'(an1),    32'(m_an(e, SD1, sm1)));
    chk("seg1",   32'(seg1),   32'(m_seg(e, SD1, sm1)));
    chk("dp1",    32'(dp1),    32'd1);
    chk("frame1", 32'(frame1), 32'(m_frame(e, SD1)));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence with hand-computed literals, then random data.
  // --------------------------------------------------------------------------
  initial begin
    din = 32'h89ABCDEF;
    step(3);
    chk("rst_an",    32'(an0),    32'h0FE);
    chk("rst_seg",   32'(seg0),   32'h040);
    chk("rst_dp",    32'(dp0),    32'h1);
    chk("rst_frame", 32'(frame0), 32'h0);

    rst = 1'b1;                       // released on a falling edge: e = 0
    step(2);                          // e = 2
    chk("rel_an_fd", 32'(an0), 32'h0FD);
    step(14);                         // e = 16: first frame load
    chk("hex_frame", 32'(frame0), 32'h1);
    chk("hex_an0",   32'(an0),    32'h0FE);
    chk("hex_seg0",  32'(seg0),   32'h00E);
    step(2);                          // e = 18
    chk("hex_an1",   32'(an0),    32'h0FD);
    chk("hex_seg1",  32'(seg0),   32'h006);
    chk("hex_nofrm", 32'(frame0), 32'h0);
    chk("sd1_an_e18", 32'(an1),   32'h0FB);

    // Frame coherence
    din = 32'h12345678;
    step(14);                         // e = 32
    chk("coh_frame", 32'(frame0), 32'h1);
    chk("coh_seg0",  32'(seg0),   32'h000);
    step(6);                          // e = 38, idx = 3
    din = 32'd0;
    chk("coh_seg3",  32'(seg0),   32'h012);
    step(2);                          // e = 40, idx = 4
    chk("coh_seg4",  32'(seg0),   32'h019);
    step(8);                          // e = 48, next frame
    chk("coh_zero0", 32'(seg0),   32'h040);
    step(14);                         // e = 62, idx = 7
    chk("coh_zero7", 32'(seg0),   32'h040);
    chk("coh_an7",   32'(an0),    32'h07F);

    // Leading-zero handling
    din = 32'h000000A5;
    step(2);                          // e = 64
    chk("lz_seg0", 32'(seg0), 32'h012);
    step(2);                          // e = 66
    chk("lz_seg1", 32'(seg0), 32'h008);
    step(2);                          // e = 68
`ifdef SEG7_LZB_EN
    chk("lz_an2",  32'(an0),  32'h0FF);
    chk("lz_seg2", 32'(seg0), 32'h07F);
`else
    chk("lz_an2",  32'(an0),  32'h0FB);
    chk("lz_seg2", 32'(seg0), 32'h040);
`endif
    din = 32'd0;
    step(12);                         // e = 80
    chk("z_seg0", 32'(seg0), 32'h040);
    step(2);                          // e = 82
`ifdef SEG7_LZB_EN
    chk("z_an1",  32'(an0),  32'h0FF);
`else
    chk("z_an1",  32'(an0),  32'h0FD);
`endif

    // Random data, many values with leading zeros
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0)
        din = $urandom >> $urandom_range(0, 31);
    end

    // Asynchronous reset mid-scan at idx = 5 with all-F shown
    din = 32'hFFFFFFFF;
    begin : wait_idx5
      int k;
      for (k = 0; k < 64; k++) begin
        @(negedge clk);
        if ((e % 16 == 10) && (sm0 == 32'hFFFFFFFF)) break;
      end
      chk("arst_reach", 32'(k < 64), 32'd1);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_an",    32'(an0),    32'h0FE);
    chk("arst_seg",   32'(seg0),   32'h040);
    chk("arst_frame", 32'(frame0), 32'h0);
    step(3);
    rst = 1'b1;
    step(15);                         // e = 15
    chk("arst_nofrm", 32'(frame0), 32'h0);
    step(1);                          // e = 16
    chk("arst_frm",   32'(frame0), 32'h1);
    chk("arst_seg0",  32'(seg0),   32'h00E);
    step(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan.md
# seg7_scan

Eight-digit multiplexed seven-segment scan driver that consumes the 32-bit syscall display word produced by the CPU's syscall-display stage. It shows that word as eight hex digits on the board's common-anode display. The value is latched once per scan frame so a frame never mixes old and new data. The block is the last stage before the FPGA display pins.

## Interface

**Parameters**
- `SCAN_DIV`, default 50000: clock cycles per digit. Must be ≥ 1. The counter width is `$clog2(SCAN_DIV)`, with a minimum of 1 bit.

**Ports**
- `clk` in, 1: system clock. All state changes on the rising edge.
- `rst` in, 1: asynchronous, active-low reset.
- `din` in, 32: display word from the syscall-display stage.
- `an` out, 8: digit enables, active-low. `an[0]` is the rightmost digit (`din[3:0]`).
- `seg` out, 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` out, 1: decimal point, active-low. Tied to 1 (off).
- `frame` out, 1: one-cycle pulse, registered, high in the cycle after a frame-boundary load.

## Operation

**State**
- `cnt`: prescaler.
- `idx[2:0]`: current digit.
- `shown[31:0]`: shadow copy of `din`.
- `frame`: registered pulse.

**Prescaler**
- `cnt` counts 0 … `SCAN_DIV-1` and then wraps to 0.
- `tick = (cnt == SCAN_DIV-1)`.

**Digit advance**
- On `tick`, `idx <= idx + 1`, wrapping 7 → 0.
- Without `tick`, `idx` holds.

**Frame load**
- On `tick && idx == 7`: `shown <= din` and `frame <= 1`.
- Otherwise `frame <= 0`.
- `din` is sampled only at this edge. Changes at any other time are ignored until the next boundary.

**Outputs**
- Outputs are combinational from registered state only. There is no combinational path from `din`.
- `an = ~(8'b1 << idx)`.
- `seg = hex7(shown[4*idx +: 4])`.

**hex7 table (active-low)**
- 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
- 8:00, 9:10, A:08, B:03, C:46, D:21, E:06, F:0E

**Reset (`rst` low, asynchronous)**
- `cnt = 0`, `idx = 0`, `shown = 0`, `frame = 0`.
- Resulting outputs: `an = 8'hFE`, `seg = 7'h40`, `dp = 1`, `frame = 0`.

## Timing

- Each digit is enabled for exactly `SCAN_DIV` cycles. A full frame is `8*SCAN_DIV` cycles.
- After reset release, the first `tick` occurs on the `SCAN_DIV`-th rising edge.
- The first frame boundary occurs on edge `8*SCAN_DIV`. It loads `din` and moves `idx` to 0 at that same edge.
- `din`-to-display latency:
  - Minimum: 0 cycles after the sampling edge. The new value is visible immediately with `idx = 0`.
  - Maximum wait for sampling: `8*SCAN_DIV` cycles.
- `frame` rises on the cycle following the loading edge.
  - With `SCAN_DIV = 1`, `frame` pulses every 8 cycles.
  - `frame` is never high for two consecutive cycles unless `SCAN_DIV = 1` … impossible, since the period is ≥ 8.
- **`SCAN_DIV = 1`:** `tick` is constant 1, so `idx` advances every cycle.
- **Reset mid-frame:** outputs return to reset values with no clock edge. The partially displayed frame is discarded.
- **Simultaneous `din` change at the boundary edge:** the value present at the edge is the one captured. Standard setup/hold applies.

## Configuration

- **Macro `SEG7_LZB_EN`** (leading-zero blanking).
  - **Defined:** digit `idx` is blank when `idx != 0` and `shown[31:4*idx] == 0`. Blank means `an = 8'hFF` and `seg = 7'h7F`. Timing is unchanged; the blanked slot still lasts `SCAN_DIV` cycles. Digit 0 is never blanked, so value 0 shows a single "0".
  - **Undefined:** all eight digits are always driven, with leading zeros shown as 40.

## Test plan

All scenarios use `SCAN_DIV = 2` unless noted.

1. **Reset values.** Hold `rst` low with the clock running. Require `an = FE`, `seg = 40`, `dp = 1`, `frame = 0` throughout. After release, require `an = FD` from edge 2 onward.
2. **Full hex display.** Hold `din = 32'h89ABCDEF` from reset release. At edge 16, require a `frame` pulse, then `an`/`seg` sequence FE/0E, FD/06, FB/21, F7/46, EF/03, DF/08, BF/10, 7F/00, two cycles each. Require `frame` to repeat every 16 cycles.
3. **Frame coherence.** Load `0x12345678`. Change `din` to 0 while `idx = 3`. Require digits 3–7 to still show 5, 4, 3, 2, 1 (12, 19, 30, 24, 79). Require the next frame to show all 40.
4. **Leading-zero blanking.** Load `din = 32'h000000A5`.
   - With `SEG7_LZB_EN`: digits 0/1 show 12/08; digits 2–7 give `an = FF`, `seg = 7F`.
   - Without it: digits 2–7 show 40.
   - `din = 0` with the macro: digit 0 shows 40 and all others are blank.
5. **Asynchronous reset mid-scan.** With `idx = 5` and `shown = 0xFFFFFFFF`, drop `rst` between clock edges. Require `an = FE` and `seg = 40` immediately, with no edge. Require the next frame load to occur `8*SCAN_DIV` cycles after release.
6. **`SCAN_DIV = 1`.** Require `an` to rotate FE → FD → … → 7F one step per cycle, and `frame` to pulse every 8 cycles.
